// File: rtl/pal_pkg.sv
// Shared constants and index helpers for the field-programmable PAL.
// bitstream_len/and_bit/or_bit define the configuration bit layout used everywhere.
package pal_pkg;

  localparam int unsigned NUM_INPUTS_DEF        = 8;
  localparam int unsigned NUM_OUTPUTS_DEF       = 8;
  localparam int unsigned NUM_INTERM_STAGES_DEF = 8;

  typedef enum logic {
    LIT_POS = 1'b0,
    LIT_NEG = 1'b1
  } lit_pol_e;

  function automatic int unsigned bitstream_len(input int unsigned ni,
                                                input int unsigned no,
                                                input int unsigned ns);
    return 2 * ni * ns + ns * no;
  endfunction

  // AND plane: two bits per input per term, true literal first
  function automatic int unsigned and_bit(input int unsigned s,
                                          input int unsigned k,
                                          input lit_pol_e    neg,
                                          input int unsigned ni = NUM_INPUTS_DEF);
    return s * 2 * ni + 2 * k + ((neg == LIT_NEG) ? 1 : 0);
  endfunction

  function automatic int unsigned or_bit(input int unsigned o,
                                         input int unsigned s,
                                         input int unsigned ni = NUM_INPUTS_DEF,
                                         input int unsigned ns = NUM_INTERM_STAGES_DEF);
    return 2 * ni * ns + o * ns + s;
  endfunction

endpackage

// File: rtl/pal_if.sv
// Pin bundle of the PAL user-project tile: enable, dedicated and bidirectional pins.
interface pal_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/pal_logic_array.sv
// Combinational AND/OR planes of the PAL, driven directly by the configuration bits.
module pal_logic_array
  import pal_pkg::*;
#(
  parameter int unsigned NUM_INPUTS        = NUM_INPUTS_DEF,
  parameter int unsigned NUM_OUTPUTS       = NUM_OUTPUTS_DEF,
  parameter int unsigned NUM_INTERM_STAGES = NUM_INTERM_STAGES_DEF,
  localparam int unsigned BITSTREAM_LEN    =
    bitstream_len(NUM_INPUTS, NUM_OUTPUTS, NUM_INTERM_STAGES)
) (
  input  logic [BITSTREAM_LEN-1:0]     cfg,
  input  logic [NUM_INPUTS-1:0]        in,
  output logic [NUM_OUTPUTS-1:0]       out
);

  logic [NUM_INTERM_STAGES-1:0] term;
  logic [NUM_INTERM_STAGES-1:0] term_used;
  logic [NUM_INTERM_STAGES-1:0] term_and;

  // A term with no selected literal must read 0, not the empty-AND identity 1
  always_comb begin
    term_used = '0;
    term_and  = '1;
    for (int unsigned s = 0; s < NUM_INTERM_STAGES; s++) begin
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
        if (cfg[and_bit(s, k, LIT_POS, NUM_INPUTS)]) begin
          term_used[s] = 1'b1;
          term_and[s]  = term_and[s] & in[k];
        end
        if (cfg[and_bit(s, k, LIT_NEG, NUM_INPUTS)]) begin
          term_used[s] = 1'b1;
          term_and[s]  = term_and[s] & ~in[k];
        end
      end
    end
    term = term_used & term_and;
  end

  always_comb begin
    out = '0;
    for (int unsigned o = 0; o < NUM_OUTPUTS; o++) begin
      for (int unsigned s = 0; s < NUM_INTERM_STAGES; s++) begin
        if (cfg[or_bit(o, s, NUM_INPUTS, NUM_INTERM_STAGES)]) begin
          out[o] = out[o] | term[s];
        end
      end
    end
  end

endmodule

// File: rtl/pal_top_wrapper.sv
// PAL user-project wrapper: serial config shift register, pin mapping and optional readback.
// Define PAL_READBACK_EN to expose cfg[0] on uio_out[1] for scan-out/chaining.
module pal_top_wrapper
  import pal_pkg::*;
#(
  parameter int unsigned NUM_INPUTS        = NUM_INPUTS_DEF,
  parameter int unsigned NUM_OUTPUTS       = NUM_OUTPUTS_DEF,
  parameter int unsigned NUM_INTERM_STAGES = NUM_INTERM_STAGES_DEF
) (
  input  logic  clk,
  input  logic  rst,
  pal_if.slave  bus
);

  localparam int unsigned BITSTREAM_LEN =
    bitstream_len(NUM_INPUTS, NUM_OUTPUTS, NUM_INTERM_STAGES);

  logic [BITSTREAM_LEN-1:0] cfg;
  logic [NUM_OUTPUTS-1:0]   pal_out;
  logic                     unused_pins;

  // New bits enter at the top so the first bit shifted in ends up in cfg[0]
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= '0;
    end else if (bus.ena) begin
      cfg <= {bus.uio_in[0], cfg[BITSTREAM_LEN-1:1]};
    end
  end

  pal_logic_array #(
    .NUM_INPUTS        (NUM_INPUTS),
    .NUM_OUTPUTS       (NUM_OUTPUTS),
    .NUM_INTERM_STAGES (NUM_INTERM_STAGES)
  ) u_array (
    .cfg (cfg),
    .in  (bus.ui_in[NUM_INPUTS-1:0]),
    .out (pal_out)
  );

  always_comb begin
    bus.uo_out                  = '0;
    bus.uo_out[NUM_OUTPUTS-1:0] = pal_out;
  end

`ifdef PAL_READBACK_EN
  always_comb begin
    bus.uio_out    = '0;
    bus.uio_out[1] = cfg[0];
    bus.uio_oe     = 8'h02;
  end
`else
  always_comb begin
    bus.uio_out = '0;
    bus.uio_oe  = '0;
  end
`endif

  assign unused_pins = &{1'b0, bus.uio_in[7:1], bus.ui_in};

endmodule

// File: tb/tb_pal_top_wrapper.sv
// Directed self-checking bench for pal_top_wrapper (default and PAL_READBACK_EN builds).
module tb_pal_top_wrapper;

  localparam int unsigned BL = 192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  pal_if bus();

  pal_top_wrapper #(
    .NUM_INPUTS        (8),
    .NUM_OUTPUTS       (8),
    .NUM_INTERM_STAGES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic shift_bits(input logic [BL-1:0] p, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.uio_in[0] = p[i];
      bus.ena       = 1'b1;
      @(posedge clk); #1;
    end
    bus.ena       = 1'b0;
    bus.uio_in[0] = 1'b0;
  endtask

  task automatic load(input logic [BL-1:0] p);
    shift_bits(p, BL);
  endtask

  task automatic apply(input string tag, input logic [7:0] ui, input logic [7:0] exp);
    bus.ui_in = ui;
    #1;
    check(tag, bus.uo_out, exp);
  endtask

  logic [BL-1:0] p;
  logic [BL-1:0] one_bit;

  initial begin
    bus.ena    = 1'b0;
    bus.ui_in  = '0;
    bus.uio_in = '0;
    @(posedge clk); #1;

    // 1: reset state
    do_reset();
    apply("rst_0f", 8'h0F, 8'h00);
    apply("rst_00", 8'h00, 8'h00);
    apply("rst_0a", 8'h0A, 8'h00);
`ifdef PAL_READBACK_EN
    check("rst_uio_out", bus.uio_out, 8'h00);
    check("rst_uio_oe", bus.uio_oe, 8'h02);
`else
    check("rst_uio_out", bus.uio_out, 8'h00);
    check("rst_uio_oe", bus.uio_oe, 8'h00);
`endif

    // 2: out0 = in0 & in1
    p = '0; p[0] = 1'b1; p[2] = 1'b1; p[128] = 1'b1;
    load(p);
    apply("and_03", 8'h03, 8'h01);
    apply("and_01", 8'h01, 8'h00);
    apply("and_02", 8'h02, 8'h00);
    apply("and_ff", 8'hFF, 8'h01);

    // 3: out1 = ~in2
    do_reset();
    p = '0; p[21] = 1'b1; p[137] = 1'b1;
    load(p);
    apply("inv_00", 8'h00, 8'h02);
    apply("inv_04", 8'h04, 8'h00);
    apply("inv_fb", 8'hFB, 8'h02);

    // 4: out0 = in0 | in1
    p = '0; p[0] = 1'b1; p[18] = 1'b1; p[128] = 1'b1; p[129] = 1'b1;
    load(p);
    apply("or_01", 8'h01, 8'h01);
    apply("or_02", 8'h02, 8'h01);
    apply("or_00", 8'h00, 8'h00);

    // Both polarities of one input selected -> term stuck at 0
    p = '0; p[0] = 1'b1; p[1] = 1'b1; p[128] = 1'b1;
    load(p);
    apply("both_01", 8'h01, 8'h00);
    apply("both_00", 8'h00, 8'h00);

    // Term with no literals selected reads 0
    p = '0; p[128] = 1'b1;
    load(p);
    apply("empty_ff", 8'hFF, 8'h00);
    apply("empty_00", 8'h00, 8'h00);

    // Highest corner: out7 = term7 = in7
    p = '0; p[126] = 1'b1; p[191] = 1'b1;
    load(p);
    apply("top_80", 8'h80, 8'h80);
    apply("top_7f", 8'h7F, 8'h00);

    // One extra leading bit is discarded by the sliding window
    p = '0; p[0] = 1'b1; p[2] = 1'b1; p[128] = 1'b1;
    one_bit = '1;
    shift_bits(one_bit, 1);
    load(p);
    apply("slide_03", 8'h03, 8'h01);
    apply("slide_01", 8'h01, 8'h00);
    apply("slide_04", 8'h04, 8'h00);

    // Reset mid-load aborts, then a fresh load works from zero
    one_bit = '1;
    shift_bits(one_bit, 100);
    do_reset();
    apply("abort_ff", 8'hFF, 8'h00);
    p = '0; p[21] = 1'b1; p[137] = 1'b1;
    load(p);
    apply("reload_00", 8'h00, 8'h02);

    // 5: ena=0 freezes cfg
    do_reset();
    p = '0; p[0] = 1'b1; p[2] = 1'b1; p[128] = 1'b1;
    load(p);
    bus.ena       = 1'b0;
    bus.uio_in[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.uio_in[0] = 1'b0;
    apply("hold_03", 8'h03, 8'h01);
    apply("hold_01", 8'h01, 8'h00);
    do_reset();
    apply("hold_rst_03", 8'h03, 8'h00);

`ifdef PAL_READBACK_EN
    // 6: readback replays the stored stream in load order
    p = 192'hA5C3_0F1E_9B27_6D48_E1F0_3C5A_7788_1234_DEAD_BEEF_0123_4567;
    load(p);
    for (int unsigned i = 0; i < BL; i++) begin
      check($sformatf("rb_%0d", i), {6'b0, bus.uio_out[1], 1'b0}, {6'b0, p[i], 1'b0});
      bus.uio_in[0] = 1'b0;
      bus.ena       = 1'b1;
      @(posedge clk); #1;
    end
    bus.ena = 1'b0;
    check("rb_oe", bus.uio_oe, 8'h02);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
